// File: rtl/priority_arbiter_rr.sv
// Arbiter: N requests -> one registered grant (index+1 code plus one-hot), fixed-priority or round-robin.
// Latency 1 cycle req->grant_valid; grant held under valid/ready. Optional PENC_STATS_EN adds grant_count.
module priority_arbiter_rr #(
  parameter int N  = 8,
  parameter int CW = $clog2(N+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          mode,
  output logic          grant_valid,
  input  logic          grant_ready,
  output logic [CW-1:0] grant_code,
  output logic [N-1:0]  grant_onehot
`ifdef PENC_STATS_EN
  ,
  output logic [15:0]   grant_count
);
`else
);
`endif

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] code_q, code_d;
  logic [N-1:0]  onehot_q, onehot_d;
  logic [PW-1:0] ptr_q, ptr_d;

  logic          accept;
  logic [PW-1:0] acc_idx;
  logic [PW-1:0] search_ptr;
  logic          win_found;
  logic [PW-1:0] win_idx;

  assign accept  = (state_q == GRANT) && grant_ready;
  assign acc_idx = PW'(code_q - CW'(1));

  always_comb begin
    ptr_d = ptr_q;
    if (accept && mode) begin
      ptr_d = acc_idx;
    end
  end

  // The search sees the pointer as updated by this edge's accept, so back-to-back grants rotate.
  assign search_ptr = mode ? ptr_d : '0;

  always_comb begin
    int            t;
    logic [PW-1:0] idx;
    t         = 0;
    idx       = '0;
    win_found = 1'b0;
    win_idx   = '0;
    // Lowest k has the highest priority, so scan it last and let it overwrite.
    for (int k = N; k >= 1; k--) begin
      t = int'(search_ptr) - k;
      if (t < 0) begin
        t = t + N;
      end
      idx = PW'(t);
      if (req[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    onehot_d = onehot_q;
    if (state_q == IDLE || accept) begin
      if (win_found) begin
        state_d  = GRANT;
        code_d   = CW'(win_idx) + CW'(1);
        onehot_d = {{(N-1){1'b0}}, 1'b1} << win_idx;
      end else begin
        state_d  = IDLE;
        code_d   = '0;
        onehot_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      code_q   <= '0;
      onehot_q <= '0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      onehot_q <= onehot_d;
      ptr_q    <= ptr_d;
    end
  end

  assign grant_valid  = (state_q == GRANT);
  assign grant_code   = code_q;
  assign grant_onehot = onehot_q;

`ifdef PENC_STATS_EN
  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (accept && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign grant_count = count_q;
`endif

endmodule

// File: tb/tb_priority_arbiter_rr.sv
// Bench for priority_arbiter_rr: directed scenarios plus random traffic against a queue scoreboard.
module tb_priority_arbiter_rr;
  localparam int N  = 8;
  localparam int CW = $clog2(N+1);

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req;
  logic          mode;
  logic          grant_valid;
  logic          grant_ready;
  logic [CW-1:0] grant_code;
  logic [N-1:0]  grant_onehot;
`ifdef PENC_STATS_EN
  logic [15:0]   grant_count;
`endif

  priority_arbiter_rr #(.N(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .mode         (mode),
    .grant_valid  (grant_valid),
    .grant_ready  (grant_ready),
    .grant_code   (grant_code),
    .grant_onehot (grant_onehot)
`ifdef PENC_STATS_EN
    ,
    .grant_count  (grant_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: currently presented winner (-1 = none), rotation pointer, accept count.
  int m_held  = -1;
  int m_ptr   = 0;
  int m_cnt   = 0;
  int snap_cnt = 0;
  int exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Fixed mode: highest requester. RR: indices below ptr descending, then N-1 down to ptr.
  function automatic int pick(input logic [N-1:0] r, input bit m, input int p);
    int start;
    start = m ? p : 0;
    for (int i = start - 1; i >= 0; i--) if (r[i]) return i;
    for (int i = N - 1; i >= start; i--) if (r[i]) return i;
    return -1;
  endfunction

  // Predicts what the coming rising edge does with the inputs now applied.
  task automatic step();
    if (m_held >= 0 && grant_ready) begin
      if (m_cnt < 65535) m_cnt++;
      if (mode) m_ptr = m_held;
      m_held = -1;
    end
    if (m_held < 0 && req != '0) begin
      m_held = pick(req, mode, m_ptr);
      exp_q.push_back(m_held);
    end
  endtask

  task automatic drive(input logic [N-1:0] r, input bit m, input bit rd);
    @(negedge clk);
    snap_cnt    = m_cnt;
    req         = r;
    mode        = m;
    grant_ready = rd;
    step();
  endtask

  // Monitor: just before each rising edge, pop and compare every grant that is being accepted.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n) begin
        if (grant_valid) begin
          chk("inv_code_nonzero", 32'(grant_code != '0), 32'd1);
          if (grant_code != '0) chk("inv_onehot", 32'(grant_onehot), 32'(1) << (grant_code - 1));
        end else begin
          chk("inv_idle_code", 32'(grant_code), 32'd0);
          chk("inv_idle_onehot", 32'(grant_onehot), 32'd0);
        end
        if (grant_valid && grant_ready) begin
          if (exp_q.size() == 0) begin
            chk("sb_unexpected_grant", 32'(grant_code), 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("sb_code", 32'(grant_code), 32'(e + 1));
            chk("sb_onehot", 32'(grant_onehot), 32'(1) << e);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rr_exp[9] = '{8, 7, 6, 5, 4, 3, 2, 1, 8};
    logic [N-1:0] r;

    rst_n = 1'b0; req = 8'hFF; mode = 1'b0; grant_ready = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_valid", 32'(grant_valid), 32'd0);
      chk("rst_code", 32'(grant_code), 32'd0);
      chk("rst_onehot", 32'(grant_onehot), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // First grant after release: highest requester.
    drive(8'hFF, 1'b0, 1'b1);
    chk("rel_valid", 32'(grant_valid), 32'd1);
    chk("rel_code", 32'(grant_code), 32'd8);
    chk("rel_onehot", 32'(grant_onehot), 32'h80);

    // Fixed priority, continuous ready.
    drive(8'h16, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive((i < 3) ? 8'h16 : 8'h00, 1'b0, 1'b1);
      chk("fixed_code", 32'(grant_code), 32'd5);
      chk("fixed_onehot", 32'(grant_onehot), 32'h10);
    end
    drive(8'h00, 1'b0, 1'b1);
    chk("fixed_idle", 32'(grant_valid), 32'd0);

    // Round-robin from ptr = 0 with all requests held.
    drive(8'hFF, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++) begin
      drive(8'hFF, 1'b1, 1'b1);
      chk($sformatf("rr_code_%0d", i), 32'(grant_code), 32'(rr_exp[i]));
    end
    drive(8'h00, 1'b0, 1'b1);
    drive(8'h00, 1'b0, 1'b1);
    chk("rr_idle", 32'(grant_valid), 32'd0);

    // Grant held under backpressure while requests drop.
    drive(8'h04, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(8'h00, 1'b0, 1'b0);
      chk("hold_code", 32'(grant_code), 32'd3);
      chk("hold_onehot", 32'(grant_onehot), 32'h04);
    end
    drive(8'h00, 1'b0, 1'b1);
    chk("hold_last_code", 32'(grant_code), 32'd3);
    drive(8'h00, 1'b0, 1'b0);
    chk("hold_release_valid", 32'(grant_valid), 32'd0);
    chk("hold_release_code", 32'(grant_code), 32'd0);

    // Asynchronous reset between edges while a grant is presented.
    drive(8'h81, 1'b1, 1'b0);
    drive(8'h81, 1'b1, 1'b0);
    chk("pre_arst_valid", 32'(grant_valid), 32'd1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(grant_valid), 32'd0);
    chk("arst_code", 32'(grant_code), 32'd0);
    chk("arst_onehot", 32'(grant_onehot), 32'd0);
    rst_n = 1'b1;
    m_held = -1; m_ptr = 0; m_cnt = 0;
    exp_q.delete();
    req = 8'h81; mode = 1'b1; grant_ready = 1'b0;
    step();
    drive(8'h81, 1'b1, 1'b1);
    chk("arst_first_code", 32'(grant_code), 32'd8);
    drive(8'h00, 1'b1, 1'b1);
    chk("arst_second_code", 32'(grant_code), 32'd1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      drive(r, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
`ifdef PENC_STATS_EN
      chk("grant_count", 32'(grant_count), 32'(snap_cnt));
`endif
    end
    drive(8'h00, 1'b0, 1'b1);
    drive(8'h00, 1'b0, 1'b1);
    drive(8'h00, 1'b0, 1'b1);
    chk("drain_valid", 32'(grant_valid), 32'd0);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/priority_arbiter_rr.md
Name: priority_arbiter_rr

Overview:
Parametrised successor to the team's 4-bit fixed-priority encoder. Takes N request lines and picks one winner. The winner is presented as a registered index code, in the same "index+1, 0 = none" convention, plus a one-hot grant. The grant is held under a valid/ready handshake. Supports fixed-priority mode (highest index wins) and round-robin mode, for register-file write-port and bus-sharing arbitration.

Parameters:
N, 8, number of request channels (2..32)
CW, $clog2(N+1), width of encoded grant code (derived, not to be overridden)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  N  request lines, bit i = channel i
mode  input  1  0 = fixed priority (highest index wins), 1 = round-robin
grant_valid  output  1  a grant is being presented
grant_ready  input  1  consumer accepts the presented grant
grant_code  output  CW  winning index+1; 0 when no grant
grant_onehot  output  N  one-hot of the winner; 0 when no grant
grant_count  output  16  accepted-grant counter (only with PENC_STATS_EN)

Behaviour:
- Reset: single clock domain, clk; rst_n asynchronous active-low.
  - While rst_n = 0: grant_valid = 0, grant_code = 0, grant_onehot = 0, state = IDLE, ptr = 0, grant_count = 0.
- FSM has two states, IDLE and GRANT.
- Winner search, combinational:
  - Fixed mode: highest set index of req.
  - RR mode: search downward from ptr-1, wrapping N-1..ptr; ptr itself is checked last. With ptr = 0 the order is N-1..0, identical to fixed mode.
- IDLE:
  - If |req at a rising edge: load winner into grant_code / grant_onehot, set grant_valid = 1, go to GRANT. Latency is 1 cycle from req to grant_valid.
  - If req = 0: stay in IDLE with outputs 0.
- GRANT:
  - Outputs held stable while grant_ready = 0, even if req changes or drops, including the granted bit. A grant is never withdrawn.
  - Accept = grant_valid & grant_ready at a rising edge.
  - On accept in RR mode: ptr <= accepted index. In fixed mode ptr is unchanged.
  - Also on accept, if |req: the next winner is computed with the updated ptr and loaded at the same edge. Back-to-back grants give one grant per cycle under continuous ready; state stays GRANT.
  - On accept with req = 0: clear outputs, go to IDLE.
- mode is sampled only at decision edges (IDLE with |req, or accept). Changing mode mid-grant does not alter the held grant.
- RR fairness: with all N requests held and grant_ready = 1, every channel is granted exactly once per N consecutive accepts.
- Invariants:
  - grant_onehot has exactly one bit set when grant_valid = 1, and 0 otherwise.
  - grant_code = 0 if and only if grant_valid = 0.
- rst_n asserted mid-grant: outputs clear immediately (asynchronous), ptr returns to 0, and a pending grant is lost.
- No X propagation: an unknown mode bit is not expected. The design must not latch; all regs are reset.

Optional Feature:
PENC_STATS_EN
- Defined: the grant_count port exists.
  - 16-bit counter, increments by 1 on each accept.
  - Saturates at 16'hFFFF (no wrap).
  - Cleared by rst_n.
- Not defined: the grant_count port and its counter logic are absent. All other behaviour is identical.

Test Plan:
- Reset: N=8, rst_n=0 while req=8'hFF -> grant_valid=0, grant_code=0, grant_onehot=0. Release rst_n -> next edge grant_code=8, grant_onehot=8'h80.
- Fixed mode: mode=0, req=8'h16, grant_ready=1 for 3 cycles -> grant_code=5 (onehot 8'h10) on every accept; ptr stays 0.
- Round-robin: mode=1, req=8'hFF held, ready=1 -> grant_code sequence 8,7,6,5,4,3,2,1,8, one per cycle.
- Hold under backpressure: grant_code=3 presented with ready=0; drop req to 8'h00 for 4 cycles -> outputs stay 3 / 8'h04. Assert ready -> after that edge grant_valid=0, state IDLE.
- Async reset mid-grant: rst_n pulses low between edges during grant_valid=1 -> outputs go to 0 before the next edge. After release with mode=1, req=8'h81 -> first grant_code=8 (ptr reset to 0).
- Stats (PENC_STATS_EN): force counter to 16'hFFFE, perform 3 accepts -> grant_count=16'hFFFF and remains there.
